conv_sa_sum_drain: RTL
======================

// Module: conv_sa_sum_drain
// PURPOSE
//  Downstream of the conv systolic-array sum row: collects the P lane-skewed 32-bit sum pairs
//  (sum1/sum2) produced when an accumulation slot finishes its last round, deskews them into
//  one aligned row, buffers rows in a small FIFO, and hands them to post-processing via valid/ready.
//  Lane i of the sum row presents its final value i cycles after lane 0.
// PARAMETERS
//  P      `P   lanes per sum row (>=2)
//  SW     32   sum width per lane
//  AW     3    accumulation-slot address width (wr_addr of the sum row)
//  DEPTH  4    FIFO depth in rows (power of 2, >=2)
// PORTS
//  clk        in   1       clock
//  rstn       in   1       asynchronous active-low reset
//  in_sum1    in   P*SW    sum row out_sum1, lane i at [i*SW+:SW]
//  in_sum2    in   P*SW    sum row out_sum2
//  in_fin_vld in   1       pulse: lane 0 holds a final sum this cycle (last_rnd completion)
//  in_fin_addr in  AW      slot address belonging to in_fin_vld
//  out_vld    out  1       FIFO head valid
//  out_rdy    in   1       consumer accepts head when out_vld&&out_rdy
//  out_sum1   out  P*SW    aligned row, sum1
//  out_sum2   out  P*SW    aligned row, sum2
//  out_addr   out  AW      slot address of head row
//  out_cnt    out  log2(DEPTH)+1  FIFO occupancy
//  out_ovf    out  1       sticky overflow flag
// BEHAVIOUR
//  - Reset (rstn=0, async): all deskew regs, FIFO pointers, out_cnt, out_vld, out_ovf -> 0; out data -> 0.
//  - Deskew: lane i of in_sum1/in_sum2 passes through a (P-1-i)-stage register chain; lane P-1 has 0 stages.
//    in_fin_vld/in_fin_addr pass through P-1 stages. At cycle t0+P-1 (t0 = in_fin_vld cycle) all lanes
//    and the flag are aligned; data sampled is lane i at cycle t0+i.
//  - Chains run every cycle (no enables); back-to-back in_fin_vld pulses each cycle are fully supported.
//  - Aligned flag high -> push {addr,sum2,sum1} into FIFO at end of cycle t0+P-1; out_vld high at t0+P if
//    FIFO was empty. Fixed latency in_fin_vld -> out_vld = P cycles.
//  - FIFO: out_* show head combinationally from storage (registered storage, no bypass). Pop on out_vld&&out_rdy.
//  - Full + push + pop same cycle: both happen, count unchanged. Full + push, no pop: row dropped,
//    out_ovf set and held until reset; FIFO contents untouched. Empty + pop impossible (out_vld=0).
//  - Empty + push + out_rdy: row not visible until next cycle (no fall-through).
//  - Pointers wrap modulo DEPTH; out_cnt = 0..DEPTH.
//  - Reset mid-operation: rows in deskew chain and FIFO discarded; no out_vld for P cycles after rstn rises
//    unless new in_fin_vld arrives.
//  - No arithmetic on sums; widths pass through unchanged.
// STRUCTURE
//  - Shared incl.vh: `P, sum width 32, slot address width 3 (used by sum row and this block).
//  - Sub-module conv_sa_drain_fifo: generic sync FIFO (WIDTH=2*P*SW+AW, DEPTH) with push/pop/full/empty/cnt,
//    drop-on-full-without-pop, ovf pulse. Deskew triangle stays in the top via generate loop.
// TESTING (P=4, DEPTH=4)
//  - Single row: in_fin_vld@t0 addr=5, lane i sum1=0x100+i at t0+i, sum2=~sum1 -> out_vld@t0+4,
//    out_sum1={0x103,0x102,0x101,0x100}, out_addr=5; out_rdy=1 pops, out_vld=0 next cycle.
//  - Back-to-back: 3 pulses t0..t0+2, distinct per-cycle lane data -> 3 rows out in order, no lane mixing.
//  - Backpressure/overflow: out_rdy=0, 5 pulses -> out_cnt=4, 5th dropped, out_ovf=1 sticky; drained rows = first 4.
//  - Full with simultaneous pop: FIFO full, out_rdy=1 on push cycle -> out_cnt stays 4, out_ovf stays 0.
//  - Reset mid-flight: pulse at t0, rstn low at t0+2 -> out_vld never rises for that row; out_cnt=0.
//  - Wrap: 10 rows with out_rdy toggling 1/0 -> all rows out in order, pointers wrap, no ovf.

Source files
------------

// File: rtl/conv_sa_sum_drain_pkg.sv
// Shared constants for the conv systolic-array sum row and its drain stage.
// Default lane count, sum/address widths and FIFO sizing live here.
package conv_sa_sum_drain_pkg;

    localparam int SA_P        = 4;
    localparam int SA_SW       = 32;
    localparam int SA_AW       = 3;
    localparam int DRAIN_DEPTH = 4;

    // Per-cycle FIFO operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int row_width(input int p, input int sw, input int aw);
        return 2 * p * sw + aw;
    endfunction

endpackage

// File: rtl/conv_sa_drain_fifo.sv
// Generic synchronous FIFO with registered storage and no fall-through.
// A push into a full FIFO without a simultaneous pop is dropped and flagged for one cycle.
module conv_sa_drain_fifo
    import conv_sa_sum_drain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic     w_full;
    logic     w_empty;
    logic     w_do_push;
    logic     w_do_pop;
    fifo_op_e w_op;

    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_op      = fifo_op_e'({w_do_pop, w_do_push});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            case (w_op)
                OP_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_cnt    <= r_cnt + CW'(1);
                end
                OP_POP: begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                    r_cnt    <= r_cnt - CW'(1);
                end
                OP_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_cnt   = r_cnt;
    assign o_ovf   = i_push && w_full && !w_do_pop;

endmodule

// File: rtl/conv_sa_sum_drain.sv
// Deskews the lane-staggered final sums of the conv sum row into aligned rows
// and queues them, with their slot address, for post-processing via valid/ready.
module conv_sa_sum_drain
    import conv_sa_sum_drain_pkg::*;
#(
    parameter int P     = SA_P,
    parameter int SW    = SA_SW,
    parameter int AW    = SA_AW,
    parameter int DEPTH = DRAIN_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [P*SW-1:0]        in_sum1,
    input  logic [P*SW-1:0]        in_sum2,
    input  logic                   in_fin_vld,
    input  logic [AW-1:0]          in_fin_addr,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [P*SW-1:0]        out_sum1,
    output logic [P*SW-1:0]        out_sum2,
    output logic [AW-1:0]          out_addr,
    output logic [$clog2(DEPTH):0] out_cnt,
    output logic                   out_ovf
);

    localparam int RW = row_width(P, SW, AW);

    logic [P*SW-1:0] w_sum1_al;
    logic [P*SW-1:0] w_sum2_al;
    logic [RW-1:0]   w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_ovf_pulse;

    logic            r_vld  [P-1];
    logic [AW-1:0]   r_addr [P-1];
    logic            r_ovf;

    // Lane i arrives i cycles after lane 0, so it is delayed by the remaining P-1-i stages.
    for (genvar i = 0; i < P; i++) begin : g_lane
        localparam int STAGES = P - 1 - i;
        if (STAGES == 0) begin : g_pass
            assign w_sum1_al[i*SW +: SW] = in_sum1[i*SW +: SW];
            assign w_sum2_al[i*SW +: SW] = in_sum2[i*SW +: SW];
        end else begin : g_chain
            logic [SW-1:0] r_s1 [STAGES];
            logic [SW-1:0] r_s2 [STAGES];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < STAGES; k++) begin
                        r_s1[k] <= '0;
                        r_s2[k] <= '0;
                    end
                end else begin
                    r_s1[0] <= in_sum1[i*SW +: SW];
                    r_s2[0] <= in_sum2[i*SW +: SW];
                    for (int k = 1; k < STAGES; k++) begin
                        r_s1[k] <= r_s1[k-1];
                        r_s2[k] <= r_s2[k-1];
                    end
                end
            end

            assign w_sum1_al[i*SW +: SW] = r_s1[STAGES-1];
            assign w_sum2_al[i*SW +: SW] = r_s2[STAGES-1];
        end
    end

    // The completion flag and its address travel with lane 0 through all P-1 stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < P - 1; k++) begin
                r_vld[k]  <= 1'b0;
                r_addr[k] <= '0;
            end
        end else begin
            r_vld[0]  <= in_fin_vld;
            r_addr[0] <= in_fin_addr;
            for (int k = 1; k < P - 1; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_addr[k] <= r_addr[k-1];
            end
        end
    end

    conv_sa_drain_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_vld[P-2]),
        .i_din   ({r_addr[P-2], w_sum2_al, w_sum1_al}),
        .i_pop   (out_rdy),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (out_cnt),
        .o_ovf   (w_ovf_pulse)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_pulse) begin
            r_ovf <= 1'b1;
        end
    end

    assign out_vld  = !w_empty;
    assign out_sum1 = w_head[P*SW-1:0];
    assign out_sum2 = w_head[2*P*SW-1:P*SW];
    assign out_addr = w_head[RW-1:2*P*SW];
    assign out_ovf  = r_ovf;

    logic w_unused;
    assign w_unused = w_full;

endmodule
